// File: rtl/stc_psum_drain_pkg.sv
// Shared types and sizing helpers for the sparse-TC partial-sum drain path.
package stc_psum_drain_pkg;

    // Default datapath configuration
    localparam int unsigned DEF_N_PE    = 4;
    localparam int unsigned DEF_N       = 16;
    localparam int unsigned DEF_DW_DATA = 32;
    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_STRIDE  = 1;

    // Drain controller state
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Bits in one PE row of partial sums
    function automatic int unsigned row_width(input int unsigned n, input int unsigned dw);
        return n * dw;
    endfunction

    // Row counter width; a single-row array still needs one bit
    function automatic int unsigned cnt_width(input int unsigned n_pe);
        return (n_pe <= 1) ? 1 : $clog2(n_pe);
    endfunction

    localparam int unsigned DEF_ROW_W = row_width(DEF_N, DEF_DW_DATA);
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_N_PE);

endpackage

// File: rtl/stc_row_mux.sv
// Combinational selection of one row out of a flattened multi-row bus.
module stc_row_mux #(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned ROW_W    = 512,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [NUM_ROWS*ROW_W-1:0] rows,
    input  logic [SEL_W-1:0]          sel,
    output logic [ROW_W-1:0]          row_data
);

    // Pick row[sel]; an out-of-range index yields zero
    always_comb begin
        row_data = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (sel == SEL_W'(i)) begin
                row_data = rows[i*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/stc_psum_drain.sv
// Snapshots accumulator partial sums on tile completion and drains them
// one PE row per beat to the output buffer, so the accumulator can start
// the next tile while the previous one is still being written back.
module stc_psum_drain
    import stc_psum_drain_pkg::*;
#(
    parameter int unsigned N_PE        = DEF_N_PE,
    parameter int unsigned N           = DEF_N,
    parameter int unsigned DW_DATA     = DEF_DW_DATA,
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned ADDR_STRIDE = DEF_STRIDE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PE*N*DW_DATA-1:0]   acc_out,
    input  logic                        tile_done,
    input  logic [AW-1:0]               base_addr,
    output logic [N_PE-1:0]             acc_restart,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*DW_DATA-1:0]        out_data,
    output logic [AW-1:0]               out_addr,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err_overrun
);

    localparam int unsigned ROW_BITS  = row_width(N, DW_DATA);
    localparam int unsigned ROW_CNT_W = cnt_width(N_PE);
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(N_PE - 1);

    drain_state_e               state;
    drain_state_e               state_next;
    logic [ROW_CNT_W-1:0]       row;
    logic [ROW_CNT_W-1:0]       row_next;
    logic [N_PE*ROW_BITS-1:0]   snapshot;
    logic [AW-1:0]              addr_base;
    logic [AW-1:0]              row_off;
    logic                       handshake;
    logic                       final_hs;
    logic                       capture;
    logic                       overrun;

    // Next-state, capture acceptance, overrun detection and restart strobe
    always_comb begin
        state_next  = state;
        row_next    = row;
        capture     = 1'b0;
        overrun     = 1'b0;
        acc_restart = '0;
        handshake   = (state == DRAIN) && out_ready;
        final_hs    = handshake && (row == LAST_ROW);

        case (state)
            IDLE: begin
                if (tile_done && !reset) begin
                    capture = 1'b1;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (row == LAST_ROW) begin
                        state_next = IDLE;
                    end else begin
                        row_next = row + ROW_CNT_W'(1);
                    end
                end
                if (tile_done && !reset) begin
                    if (final_hs) begin
                        capture = 1'b1;
                    end else begin
                        overrun = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new tile overrides the return to IDLE: zero-bubble restart at row 0
        if (capture) begin
            state_next  = DRAIN;
            row_next    = '0;
            acc_restart = '1;
        end
    end

    // Control state; a mid-drain reset aborts the tile immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;
            row   <= row_next;
            if (overrun) begin
                err_overrun <= 1'b1;
            end
        end
    end

    // Tile snapshot and base address; contents only matter while draining
    always_ff @(posedge clk) begin
        if (capture) begin
            snapshot  <= acc_out;
            addr_base <= base_addr;
        end
    end

    // Row address generation, wrapping modulo 2^AW
    always_comb begin
        row_off  = AW'(row) * AW'(ADDR_STRIDE);
        out_addr = addr_base + row_off;
    end

    // Beat framing derived from the registered state and row counter
    always_comb begin
        out_valid = (state == DRAIN);
        busy      = (state == DRAIN);
        out_last  = (state == DRAIN) && (row == LAST_ROW);
    end

    stc_row_mux #(
        .NUM_ROWS (N_PE),
        .ROW_W    (ROW_BITS),
        .SEL_W    (ROW_CNT_W)
    ) u_row_mux (
        .rows     (snapshot),
        .sel      (row),
        .row_data (out_data)
    );

endmodule

// File: tb/tb_stc_psum_drain.sv
// Self-checking bench for stc_psum_drain: directed scenarios plus a random
// run, all checked against a beat-queue model of the drain behaviour.
module tb_stc_psum_drain;

    localparam int unsigned N_PE   = 4;
    localparam int unsigned N      = 16;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 16;
    localparam int unsigned STRIDE = 1;
    localparam int unsigned ROW_W  = N * DW;
    localparam int unsigned BUS_W  = N_PE * ROW_W;

    // Second instance for address wrap: AW=8, stride 2
    localparam int unsigned W_NPE  = 4;
    localparam int unsigned W_N    = 2;
    localparam int unsigned W_DW   = 8;
    localparam int unsigned W_AW   = 8;
    localparam int unsigned W_ROW  = W_N * W_DW;
    localparam int unsigned W_BUS  = W_NPE * W_ROW;

    typedef struct packed {
        logic [ROW_W-1:0] data;
        logic [AW-1:0]    addr;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [BUS_W-1:0]  acc_out;
    logic              tile_done;
    logic [AW-1:0]     base_addr;
    logic [N_PE-1:0]   acc_restart;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic [AW-1:0]     out_addr;
    logic              out_last;
    logic              busy;
    logic              err_overrun;

    logic              w_reset;
    logic [W_BUS-1:0]  w_acc;
    logic              w_tile_done;
    logic [W_AW-1:0]   w_base;
    logic [W_NPE-1:0]  w_restart;
    logic              w_valid;
    logic              w_ready;
    logic [W_ROW-1:0]  w_data;
    logic [W_AW-1:0]   w_addr;
    logic              w_last;
    logic              w_busy;
    logic              w_err;

    stc_psum_drain #(
        .N_PE(N_PE), .N(N), .DW_DATA(DW), .AW(AW), .ADDR_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .reset(reset), .acc_out(acc_out), .tile_done(tile_done),
        .base_addr(base_addr), .acc_restart(acc_restart), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .err_overrun(err_overrun)
    );

    stc_psum_drain #(
        .N_PE(W_NPE), .N(W_N), .DW_DATA(W_DW), .AW(W_AW), .ADDR_STRIDE(2)
    ) dut_wrap (
        .clk(clk), .reset(w_reset), .acc_out(w_acc), .tile_done(w_tile_done),
        .base_addr(w_base), .acc_restart(w_restart), .out_valid(w_valid),
        .out_ready(w_ready), .out_data(w_data), .out_addr(w_addr),
        .out_last(w_last), .busy(w_busy), .err_overrun(w_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: queue of beats still owed to the sink
    beat_t            q[$];
    logic             m_err = 1'b0;
    logic             m_accept;
    logic             c_rst, c_td, c_rdy;
    logic [AW-1:0]    c_base;
    logic [BUS_W-1:0] c_acc;

    logic             e_valid, e_last, e_busy, e_err;
    logic [N_PE-1:0]  e_restart;
    logic [ROW_W-1:0] e_data;
    logic [AW-1:0]    e_addr;

    // Drive one cycle of inputs and derive this cycle's expected outputs
    task automatic apply(input logic rst, input logic td, input logic rdy,
                         input logic [AW-1:0] base, input logic [BUS_W-1:0] acc);
        @(negedge clk);
        reset = rst; tile_done = td; out_ready = rdy; base_addr = base; acc_out = acc;
        c_rst = rst; c_td = td; c_rdy = rdy; c_base = base; c_acc = acc;
        #1;
        e_valid   = (q.size() != 0);
        e_data    = e_valid ? q[0].data : '0;
        e_addr    = e_valid ? q[0].addr : '0;
        e_last    = e_valid && q[0].last;
        e_busy    = e_valid;
        e_err     = m_err;
        m_accept  = !rst && td && ((q.size() == 0) || ((q.size() == 1) && rdy));
        e_restart = m_accept ? '1 : '0;
    endtask

    // Advance the model across the clock edge that follows apply()
    task automatic commit();
        beat_t b;
        if (c_rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (e_valid && c_rdy) void'(q.pop_front());
            if (m_accept) begin
                for (int r = 0; r < int'(N_PE); r++) begin
                    b.data = c_acc[r*ROW_W +: ROW_W];
                    b.addr = AW'((int'(c_base) + r * int'(STRIDE)) % (1 << AW));
                    b.last = (r == int'(N_PE) - 1);
                    q.push_back(b);
                end
            end else if (c_td) begin
                m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [ROW_W-1:0] row_rk(input int r);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < int'(N); k++) v[k*DW +: DW] = DW'(r * 100 + k);
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] pat_rk();
        logic [BUS_W-1:0] v;
        for (int r = 0; r < int'(N_PE); r++) v[r*ROW_W +: ROW_W] = row_rk(r);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] row_aa();
        logic [ROW_W-1:0] v;
        for (int k = 0; k < int'(N); k++) v[k*DW +: DW] = DW'(32'hAAAA_0000 + k);
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] v;
        for (int i = 0; i < int'(BUS_W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        w_reset = 1'b1; w_tile_done = 1'b0; w_ready = 1'b0; w_base = '0; w_acc = '0;
        apply(1'b1, 1'b1, 1'b0, '0, '0);
        commit();
        apply(1'b1, 1'b1, 1'b1, '0, '0);
        tests++;
        if ({out_valid, out_last, busy, err_overrun, acc_restart} !== 8'b0) begin
            fails++;
            $display("FAIL reset: v/l/b/e=%b%b%b%b restart=%b, want 0000 restart=0000",
                     out_valid, out_last, busy, err_overrun, acc_restart);
        end
        commit();
        w_reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, '0, '0);
        tests++;
        if ({out_valid, out_last, busy, err_overrun, acc_restart} !== 8'b0) begin
            fails++;
            $display("FAIL reset_idle: v/l/b/e=%b%b%b%b restart=%b, want 0000 restart=0000",
                     out_valid, out_last, busy, err_overrun, acc_restart);
        end
        commit();
    endtask

    task automatic test_basic_drain();
        int hs = 0;
        apply(1'b0, 1'b1, 1'b1, 16'h0040, pat_rk());
        tests++;
        if (acc_restart !== 4'b1111) begin
            fails++; $display("FAIL basic_restart: got %b want 1111", acc_restart);
        end
        commit();
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 1'b0, 1'b1, '0, '0);
            tests++;
            if ({out_valid, out_last, busy, err_overrun, acc_restart} !== {e_valid, e_last, e_busy, e_err, e_restart}
                || (e_valid && {out_data, out_addr} !== {e_data, e_addr})) begin
                fails++;
                $display("FAIL basic c%0d: vlbe=%b%b%b%b r=%b a=%h d=%h want %b%b%b%b r=%b a=%h d=%h",
                         c, out_valid, out_last, busy, err_overrun, acc_restart, out_addr, out_data,
                         e_valid, e_last, e_busy, e_err, e_restart, e_addr, e_data);
            end
            if (c < 4) begin
                tests++;
                if (out_valid !== 1'b1 || out_addr !== AW'(16'h0040 + hs) || out_data !== row_rk(hs)
                    || out_last !== (hs == 3)) begin
                    fails++;
                    $display("FAIL basic_beat%0d: v=%b a=%h l=%b d=%h want v=1 a=%h l=%b d=%h",
                             hs, out_valid, out_addr, out_last, out_data, 16'h0040 + hs, hs == 3, row_rk(hs));
                end
                hs++;
            end
            commit();
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL basic_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic rdy_pat[12] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        int hs = 0;
        apply(1'b0, 1'b1, 1'b0, 16'h1230, rand_bus());
        commit();
        for (int c = 0; c < 12; c++) begin
            apply(1'b0, 1'b0, rdy_pat[c], '0, '0);
            tests++;
            if ({out_valid, out_last, busy, err_overrun, acc_restart} !== {e_valid, e_last, e_busy, e_err, e_restart}
                || (e_valid && {out_data, out_addr} !== {e_data, e_addr})) begin
                fails++;
                $display("FAIL backpressure c%0d: vlbe=%b%b%b%b a=%h d=%h want %b%b%b%b a=%h d=%h",
                         c, out_valid, out_last, busy, err_overrun, out_addr, out_data,
                         e_valid, e_last, e_busy, e_err, e_addr, e_data);
            end
            if (out_valid && out_ready) hs++;
            commit();
        end
        tests++;
        if (hs != 4) begin
            fails++; $display("FAIL backpressure_count: got %0d handshakes want 4", hs);
        end
    endtask

    task automatic test_back_to_back();
        logic [BUS_W-1:0] t2;
        for (int r = 0; r < int'(N_PE); r++) t2[r*ROW_W +: ROW_W] = row_aa();
        apply(1'b0, 1'b1, 1'b1, 16'h0000, rand_bus());
        commit();
        for (int c = 0; c < 9; c++) begin
            apply(1'b0, c == 3, 1'b1, 16'h0080, t2);
            tests++;
            if ({out_valid, out_last, busy, err_overrun, acc_restart} !== {e_valid, e_last, e_busy, e_err, e_restart}
                || (e_valid && {out_data, out_addr} !== {e_data, e_addr})) begin
                fails++;
                $display("FAIL b2b c%0d: vlbe=%b%b%b%b r=%b a=%h d=%h want %b%b%b%b r=%b a=%h d=%h",
                         c, out_valid, out_last, busy, err_overrun, acc_restart, out_addr, out_data,
                         e_valid, e_last, e_busy, e_err, e_restart, e_addr, e_data);
            end
            if (c == 3) begin
                tests++;
                if (acc_restart !== 4'b1111 || out_last !== 1'b1) begin
                    fails++; $display("FAIL b2b_restart: restart=%b last=%b want 1111 1", acc_restart, out_last);
                end
            end
            if (c == 4) begin
                tests++;
                if (out_valid !== 1'b1 || out_addr !== 16'h0080 || out_data !== row_aa()) begin
                    fails++; $display("FAIL b2b_first: v=%b a=%h d=%h want 1 0080 %h", out_valid, out_addr, out_data, row_aa());
                end
            end
            if (c < 8) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++; $display("FAIL b2b_bubble c%0d: out_valid=%b want 1", c, out_valid);
                end
            end
            commit();
        end
    endtask

    task automatic test_overrun();
        logic [BUS_W-1:0] t1;
        t1 = rand_bus();
        apply(1'b0, 1'b1, 1'b1, 16'h0200, t1);
        commit();
        for (int c = 0; c < 7; c++) begin
            apply(1'b0, c == 1, c != 1, 16'h0300, rand_bus());
            tests++;
            if ({out_valid, out_last, busy, err_overrun, acc_restart} !== {e_valid, e_last, e_busy, e_err, e_restart}
                || (e_valid && {out_data, out_addr} !== {e_data, e_addr})) begin
                fails++;
                $display("FAIL overrun c%0d: vlbe=%b%b%b%b r=%b a=%h d=%h want %b%b%b%b r=%b a=%h d=%h",
                         c, out_valid, out_last, busy, err_overrun, acc_restart, out_addr, out_data,
                         e_valid, e_last, e_busy, e_err, e_restart, e_addr, e_data);
            end
            if (c == 1) begin
                tests++;
                if (acc_restart !== 4'b0000 || out_data !== t1[ROW_W +: ROW_W]) begin
                    fails++; $display("FAIL overrun_drop: restart=%b want 0000, beat data=%h want %h",
                                      acc_restart, out_data, t1[ROW_W +: ROW_W]);
                end
            end
            if (c >= 2) begin
                tests++;
                if (err_overrun !== 1'b1) begin
                    fails++; $display("FAIL overrun_sticky c%0d: err_overrun=%b want 1", c, err_overrun);
                end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [BUS_W-1:0] t2;
        t2 = rand_bus();
        apply(1'b0, 1'b1, 1'b1, 16'h0500, rand_bus());
        commit();
        apply(1'b0, 1'b0, 1'b1, '0, '0);
        commit();
        apply(1'b1, 1'b0, 1'b1, '0, '0);
        commit();
        apply(1'b0, 1'b1, 1'b1, 16'h0600, t2);
        tests++;
        if ({out_valid, busy, err_overrun} !== 3'b000 || acc_restart !== 4'b1111) begin
            fails++; $display("FAIL reset_mid: v/b/e=%b%b%b restart=%b want 000 1111",
                              out_valid, busy, err_overrun, acc_restart);
        end
        commit();
        apply(1'b0, 1'b0, 1'b0, '0, '0);
        tests++;
        if (out_valid !== 1'b1 || out_addr !== 16'h0600 || out_data !== t2[ROW_W-1:0]) begin
            fails++; $display("FAIL reset_mid_restart: v=%b a=%h d=%h want 1 0600 %h",
                              out_valid, out_addr, out_data, t2[ROW_W-1:0]);
        end
        commit();
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 1'b0, 1'b1, '0, '0);
            commit();
        end
    endtask

    task automatic test_random();
        logic rst, td, rdy;
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            td  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            apply(rst, td, rdy, AW'($urandom), rand_bus());
            tests++;
            if ({out_valid, out_last, busy, err_overrun, acc_restart} !== {e_valid, e_last, e_busy, e_err, e_restart}
                || (e_valid && {out_data, out_addr} !== {e_data, e_addr})) begin
                fails++;
                $display("FAIL random c%0d: vlbe=%b%b%b%b r=%b a=%h d=%h want %b%b%b%b r=%b a=%h d=%h",
                         c, out_valid, out_last, busy, err_overrun, acc_restart, out_addr, out_data,
                         e_valid, e_last, e_busy, e_err, e_restart, e_addr, e_data);
            end
            commit();
        end
    endtask

    task automatic test_addr_wrap();
        logic [W_AW-1:0] exp_addr [4] = '{8'hFC, 8'hFE, 8'h00, 8'h02};
        @(negedge clk);
        w_acc = 64'h4444_3333_2222_1111;
        w_base = 8'hFC; w_ready = 1'b1; w_tile_done = 1'b1;
        #1;
        tests++;
        if (w_restart !== 4'b1111) begin
            fails++; $display("FAIL wrap_restart: got %b want 1111", w_restart);
        end
        @(negedge clk);
        w_tile_done = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            tests++;
            if (w_valid !== 1'b1 || w_addr !== exp_addr[b] || w_data !== w_acc[b*W_ROW +: W_ROW]
                || w_last !== (b == 3)) begin
                fails++;
                $display("FAIL wrap_beat%0d: v=%b a=%h d=%h l=%b want 1 %h %h %b", b, w_valid, w_addr, w_data,
                         w_last, exp_addr[b], w_acc[b*W_ROW +: W_ROW], b == 3);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (w_valid !== 1'b0 || w_busy !== 1'b0 || w_err !== 1'b0) begin
            fails++; $display("FAIL wrap_idle: v/b/e=%b%b%b want 000", w_valid, w_busy, w_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid_drain();
        test_random();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
